spram_arbiter: RTL and testbench
================================

# spram_arbiter

Two-port round-robin arbiter that shares one single_port_ram instance between requester A and requester B. Each requester issues read or write commands with a req/gnt handshake. The arbiter registers the winning command onto the RAM port and returns read data to the originating requester with a fixed latency and an rvalid strobe. It sits directly in front of the RAM. All RAM traffic in the subsystem goes through it.

## Interface
- ADDR_WIDTH, 4, RAM address width
- DATA_WIDTH, 8, RAM data width

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  requester A command valid
- a_we  in  1  A command type, 1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  A address
- a_wdata  in  DATA_WIDTH  A write data
- a_gnt  out  1  A command accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid (one-cycle pulse)
- a_rdata  out  DATA_WIDTH  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDR_WIDTH  registered RAM address
- ram_din  out  DATA_WIDTH  registered RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data, valid one clk after address sampled

## Operation
- Arbitration is combinational from the req lines and a 1-bit priority pointer ptr (0 = A favoured).
  - Only one requester active: that requester is granted.
  - Both active: the ptr side is granted.
  - a_gnt and b_gnt are never high together, and both are 0 while rst is high.
- Accept happens when x_req & x_gnt is high at a rising edge.
- ptr update: after any accept with both req high, ptr points to the loser. A single-requester accept leaves ptr unchanged.
- Pipeline, with one command accepted per cycle max:
  - S1 (edge N): register ram_we/ram_addr/ram_din from the winner. Also register s1_valid, s1_rd (= valid & ~we) and s1_port.
    - With no accept, ram_we goes to 0. ram_addr/ram_din hold.
  - RAM samples at edge N+1.
  - S2 (edge N+1): shift s1_rd/s1_port into s2.
  - S3 (edge N+2): if s2_rd, register ram_dout into x_rdata of s2_port and pulse x_rvalid for one cycle.
  - The other port's rdata holds its previous value.
- Writes produce no rvalid.
- Commands complete in acceptance order. A read accepted the cycle after a write to the same address returns the new data, because the RAM sees them in order.
- The requester must hold req/we/addr/wdata stable until gnt is seen at an edge. The arbiter does not latch unaccepted commands.
- Backpressure: none on the read return path. The requester must accept rvalid when it occurs.

## Timing
- Reset values (async, immediate):
  - ptr=0
  - s1/s2 valid=0
  - ram_we=0, ram_addr=0, ram_din=0
  - a_rvalid=b_rvalid=0
  - a_rdata=b_rdata=0
  - gnt forced 0
- Read latency: accepted at edge N, rvalid high for the cycle after edge N+2.
- Write latency: accepted at edge N, RAM written at edge N+1.
- Throughput: one command per clk. Back-to-back alternation under contention gives A, B, A, B.
- Simultaneous events: rvalid for an older read and gnt for a new command may occur in the same cycle. Both ports may have rvalid in consecutive cycles, but never in the same cycle.
- Reset mid-operation:
  - All in-flight commands are dropped and no rvalid is issued afterward.
  - A write accepted at edge N is lost if rst rises before edge N+1, because ram_we clears.
- Address wrap: addresses are used as-is, with no arithmetic.

## Test plan
- Reset check: assert rst mid-run. Required: every output at its reset value immediately, a_gnt=b_gnt=0 while rst is high, and no rvalid after release until new reads.
- Single requester: A writes 0xAA to addr 0, then reads addr 0. Required: a_gnt each cycle, ram_we=1 for one cycle, and a_rvalid pulses with a_rdata=0xAA two cycles after the read accept. b_rvalid stays 0.
- Contention: A and B both request continuously, A writes 0x55 to addr 1 and B reads addr 1, ptr=0. Required: A granted first, then B. b_rdata=0x55 at b_rvalid.
- Round-robin fairness: both hold reads for 6 cycles. Required: grants alternate A, B, A, B, A, B. Rvalids alternate ports, each 2 cycles after its accept.
- Pipelined reads: after filling addrs 0–3 with 0x10–0x13, A issues reads to 0, 1, 2, 3 back to back. Required: a_rvalid high 4 consecutive cycles with 0x10, 0x11, 0x12, 0x13.
- Reset during read: A read accepted, rst pulsed at the next cycle. Required: no a_rvalid. a_rdata=0, ptr=0.

Source files
------------

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - round-robin two-requester arbiter in front of a single-port RAM
module spram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic                  ptr_q, ptr_d;
    logic                  accept;
    logic                  win_b;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    logic                  ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_din_q;
    logic                  s1_valid_q, s1_rd_q, s1_port_q;
    logic                  s2_valid_q, s2_rd_q, s2_port_q;
    logic                  a_rvalid_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

    // ptr = 0 favours A on contention; it then moves to whichever side lost.
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        if (!rst) begin
            if (a_req && (!b_req || !ptr_q)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
        accept    = a_gnt | b_gnt;
        win_b     = b_gnt;
        win_we    = win_b ? b_we    : a_we;
        win_addr  = win_b ? b_addr  : a_addr;
        win_wdata = win_b ? b_wdata : a_wdata;
        ptr_d     = ptr_q;
        if (a_req && b_req && accept) begin
            ptr_d = a_gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_rd_q    <= 1'b0;
            s1_port_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_rd_q    <= 1'b0;
            s2_port_q  <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            ram_we_q   <= accept & win_we;
            if (accept) begin
                ram_addr_q <= win_addr;
                ram_din_q  <= win_wdata;
            end
            s1_valid_q <= accept;
            s1_rd_q    <= accept & ~win_we;
            s1_port_q  <= win_b;
            s2_valid_q <= s1_valid_q;
            s2_rd_q    <= s1_rd_q;
            s2_port_q  <= s1_port_q;
            // RAM output is valid here, two edges after the command was accepted.
            a_rvalid_q <= s2_valid_q & s2_rd_q & ~s2_port_q;
            b_rvalid_q <= s2_valid_q & s2_rd_q &  s2_port_q;
            if (s2_valid_q && s2_rd_q && !s2_port_q) begin
                a_rdata_q <= ram_dout;
            end
            if (s2_valid_q && s2_rd_q && s2_port_q) begin
                b_rdata_q <= ram_dout;
            end
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - directed scoreboard bench for spram_arbiter
module tb_spram_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port RAM: samples address on the edge, data out one clock later.
    logic [DW-1:0] mem    [16];
    logic [DW-1:0] shadow [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            cyc;
    } rd_t;
    rd_t sb[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic          m_ptr    = 1'b0;
    logic [DW-1:0] last_a   = '0;
    logic [DW-1:0] last_b   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read-return monitor: pops the scoreboard whenever an rvalid appears.
    always @(negedge clk) begin
        rd_t e;
        if (rst) begin
            last_a = '0;
            last_b = '0;
        end else if (a_rvalid || b_rvalid) begin
            chk("rvalid_exclusive", {31'd0, a_rvalid & b_rvalid}, 32'd0);
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", {30'd0, a_rvalid, b_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rv_port", {31'd0, b_rvalid}, {31'd0, e.port});
                chk("rv_data", {24'd0, e.port ? b_rdata : a_rdata}, {24'd0, e.data});
                chk("rv_cycle", cyc, e.cyc);
                chk("rdata_hold", {24'd0, e.port ? a_rdata : b_rdata}, {24'd0, e.port ? last_a : last_b});
            end
            if (a_rvalid) last_a = a_rdata;
            if (b_rvalid) last_b = b_rdata;
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk("rv_missing", {31'd0, a_rvalid | b_rvalid}, 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic step(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        logic          ea, eb, acc, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        @(negedge clk);
        ea   = !rst && ar && (!br || !m_ptr);
        eb   = !rst && br && !ea;
        chk("a_gnt", {31'd0, a_gnt}, {31'd0, ea});
        chk("b_gnt", {31'd0, b_gnt}, {31'd0, eb});
        acc  = ea || eb;
        we   = eb ? bw : aw;
        addr = eb ? ba : aa;
        data = eb ? bd : ad;
        if (acc) begin
            if (ar && br) m_ptr = ea;
            if (we) shadow[addr] = data;
            else    sb.push_back('{eb, shadow[addr], cyc + 3});
        end
        @(posedge clk);
        #1;
        chk("ram_we", {31'd0, ram_we}, {31'd0, acc && we});
        if (acc && we) begin
            chk("ram_addr", {28'd0, ram_addr}, {28'd0, addr});
            chk("ram_din", {24'd0, ram_din}, {24'd0, data});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
        chk("rst_ram_din", {24'd0, ram_din}, 32'd0);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
        chk("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]    = 8'hC0 + 8'(i);
            shadow[i] = 8'hC0 + 8'(i);
        end
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single requester write then read-back
        step(1, 1, 4'd0, 8'hAA, 0, 0, 0, 0);
        step(1, 0, 4'd0, 8'h00, 0, 0, 0, 0);
        idle(4);

        // Contention: A writes addr 1, B reads it
        step(1, 1, 4'd1, 8'h55, 1, 0, 4'd1, 8'h00);
        step(0, 0, 4'd0, 8'h00, 1, 0, 4'd1, 8'h00);
        idle(4);

        // Round-robin fairness with both holding reads
        if (m_ptr) step(1, 0, 4'd5, 0, 1, 0, 4'd6, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 4'(i), 0, 1, 0, 4'(15 - i), 0);
        idle(4);

        // Fill 0..3 then back-to-back reads
        for (int i = 0; i < 4; i++) step(1, 1, 4'(i), 8'h10 + 8'(i), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 4'(i), 0, 0, 0, 0, 0);
        idle(5);
        chk("sb_drained", sb.size(), 32'd0);

        // Reset during read, with ptr steered to B beforehand
        for (int i = 0; i < 2 && !m_ptr; i++) step(1, 0, 4'd7, 0, 1, 0, 4'd8, 0);
        step(1, 0, 4'd2, 0, 0, 0, 0, 0);
        rst = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        sb.delete();
        m_ptr = 1'b0;
        #1;
        check_reset_outputs();
        step(1, 0, 4'd2, 0, 1, 0, 4'd3, 0);
        step(1, 0, 4'd2, 0, 1, 0, 4'd3, 0);
        rst = 1'b0;
        idle(5);
        chk("post_rst_a_rdata", {24'd0, a_rdata}, 32'd0);
        step(1, 0, 4'd3, 0, 1, 0, 4'd2, 0);
        step(0, 0, 4'd0, 0, 1, 0, 4'd2, 0);
        idle(5);
        chk("sb_drained_end", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
